// File: rtl/tone_gen_pkg.sv
// tone_gen_pkg: shared constants, types and the quarter-wave sine table
// for the tone_gen DDS sine source.
package tone_gen_pkg;

  localparam int DEF_PHASE_W = 16;
  localparam int DEF_CLK_DIV = 3;
  localparam int LUT_AW      = 6;
  localparam int LUT_N       = (1 << LUT_AW) + 1;
  localparam int MAG_W       = 15;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    QUAD0 = 2'd0,
    QUAD1 = 2'd1,
    QUAD2 = 2'd2,
    QUAD3 = 2'd3
  } quadrant_e;

  // Entry k = round(32767 * sin(k * pi / 128)), k = 0..64.
  localparam logic [MAG_W-1:0] QUARTER_ROM [0:LUT_N-1] = '{
    15'd0,     15'd804,   15'd1608,  15'd2410,  15'd3212,
    15'd4011,  15'd4808,  15'd5602,  15'd6393,  15'd7179,
    15'd7962,  15'd8739,  15'd9512,  15'd10278, 15'd11039,
    15'd11793, 15'd12539, 15'd13279, 15'd14010, 15'd14732,
    15'd15446, 15'd16151, 15'd16846, 15'd17530, 15'd18204,
    15'd18868, 15'd19519, 15'd20159, 15'd20787, 15'd21403,
    15'd22005, 15'd22594, 15'd23170, 15'd23731, 15'd24279,
    15'd24811, 15'd25329, 15'd25832, 15'd26319, 15'd26790,
    15'd27245, 15'd27683, 15'd28105, 15'd28510, 15'd28898,
    15'd29268, 15'd29621, 15'd29956, 15'd30273, 15'd30571,
    15'd30852, 15'd31113, 15'd31356, 15'd31580, 15'd31785,
    15'd31971, 15'd32137, 15'd32285, 15'd32412, 15'd32521,
    15'd32609, 15'd32678, 15'd32728, 15'd32757, 15'd32767
  };

  // Quadrants 1 and 3 read the table backwards.
  function automatic logic is_mirrored(input quadrant_e q);
    return (q == QUAD1) || (q == QUAD3);
  endfunction

  // Quadrants 2 and 3 are the negative half-cycle.
  function automatic logic is_negative(input quadrant_e q);
    return (q == QUAD2) || (q == QUAD3);
  endfunction

endpackage

// File: rtl/tone_quarter_rom.sv
// tone_quarter_rom: registered quarter-wave sine magnitude lookup.
// Magnitude for addr_i appears on mag_o one clock later.
module tone_quarter_rom
  import tone_gen_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [LUT_AW:0]  addr_i,
  output logic [MAG_W-1:0] mag_o
);

  logic [MAG_W-1:0] mag_q;

  // Registered table read; addresses above 2^LUT_AW are never generated.
  always_ff @(posedge clk_i) begin
    if (rst_i) mag_q <= '0;
    else       mag_q <= QUARTER_ROM[addr_i];
  end

  assign mag_o = mag_q;

endmodule

// File: rtl/tone_gen.sv
// tone_gen: DDS sine test-tone source, one signed 16-bit sample every
// CLK_DIV clocks. Optional build macro TONE_GEN_GAIN_EN enables the
// arithmetic attenuation shift by gain; without it gain is ignored.
// sample_valid is a one-cycle strobe marking each new toneOut value;
// there is no backpressure, the consumer must take every sample.
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic               clk_144,
  input  logic               reset,
  input  logic               enable,
  input  logic               sync,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [2:0]         gain,
  output sample_t            toneOut,
  output logic               sample_valid
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [LUT_AW:0] ROM_TOP = (LUT_AW + 1)'(1 << LUT_AW);

  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic               tick;
  logic [PHASE_W-1:0] phase_q, phase_d;
  quadrant_e          quad;
  logic [LUT_AW-1:0]  idx;
  logic [LUT_AW:0]    rom_addr;
  logic [MAG_W-1:0]   rom_mag;
  logic               neg_q, mute_q, vld1_q;
  sample_t            mag_s, sample_c;
  sample_t            tone_q, tone_d;
  logic               valid_q;

  assign tick = (div_cnt_q == CNT_W'(CLK_DIV - 1));
  assign quad = quadrant_e'(phase_q[PHASE_W-1 -: 2]);
  assign idx  = phase_q[PHASE_W-3 -: LUT_AW];

  // Sample-rate divider and phase accumulator next state.
  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
    phase_d   = phase_q;
    if (tick) begin
      if (sync)        phase_d = '0;
      else if (enable) phase_d = phase_q + freq_word;
    end
  end

  // Divider and phase registers.
  always_ff @(posedge clk_144) begin
    if (reset) begin
      div_cnt_q <= '0;
      phase_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
    end
  end

  // Fold the quadrant onto the quarter-wave table address.
  always_comb begin
    rom_addr = {1'b0, idx};
    if (is_mirrored(quad)) rom_addr = ROM_TOP - {1'b0, idx};
  end

  tone_quarter_rom u_rom (
    .clk_i  (clk_144),
    .rst_i  (reset),
    .addr_i (rom_addr),
    .mag_o  (rom_mag)
  );

  // Stage 1: sign, mute and valid travel alongside the registered ROM read.
  always_ff @(posedge clk_144) begin
    if (reset) begin
      neg_q  <= 1'b0;
      mute_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      neg_q  <= is_negative(quad);
      mute_q <= ~enable;
      vld1_q <= tick;
    end
  end

  // Stage 2 next value: apply sign, mute and optional attenuation.
  always_comb begin
    mag_s    = sample_t'({1'b0, rom_mag});
    sample_c = '0;
    if (!mute_q) sample_c = neg_q ? -mag_s : mag_s;
    tone_d = tone_q;
    if (vld1_q) begin
`ifdef TONE_GEN_GAIN_EN
      tone_d = sample_c >>> gain;
`else
      tone_d = sample_c;
`endif
    end
  end

`ifndef TONE_GEN_GAIN_EN
  logic unused_gain;
  assign unused_gain = ^gain;
`endif

  // Stage 2: output sample register and its one-cycle strobe.
  always_ff @(posedge clk_144) begin
    if (reset) begin
      tone_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tone_q  <= tone_d;
      valid_q <= vld1_q;
    end
  end

  assign toneOut      = tone_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed and randomized bench for tone_gen with a
// sine-arithmetic reference model and an expected-sample queue.
module tb_tone_gen;

  localparam int CLK_DIV = 3;
  localparam real PI = 3.14159265358979323846;

  logic               clk_144 = 1'b0;
  logic               reset;
  logic               enable;
  logic               sync;
  logic [15:0]        freq_word;
  logic [2:0]         gain;
  logic signed [15:0] toneOut;
  logic               sample_valid;

  int total = 0;
  int bad   = 0;

  // model / scoreboard state
  int                 cyc;
  int                 m_div;
  int unsigned        m_phase;
  int                 m_ticks;
  int                 first_vld;
  logic signed [15:0] m_last;
  logic signed [15:0] exp_q[$];
  int                 exp_cyc_q[$];
  logic signed [15:0] got_q[$];

  // clock / reset block
  always #5 clk_144 = ~clk_144;

  tone_gen dut (
    .clk_144      (clk_144),
    .reset        (reset),
    .enable       (enable),
    .sync         (sync),
    .freq_word    (freq_word),
    .gain         (gain),
    .toneOut      (toneOut),
    .sample_valid (sample_valid)
  );

  task automatic chk(input string tag, input int obs, input int expv, input int tol);
    total++;
    if ((obs - expv > tol) || (expv - obs > tol)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Sine of the truncated 8-bit phase angle, rounded to nearest.
  function automatic int ref_sample(input int unsigned ph);
    int unsigned k;
    real a;
    k = (ph >> 8) & 32'd255;
    a = 32767.0 * $sin(2.0 * PI * real'(k) / 256.0);
    return int'(a);
  endfunction

  task automatic model_clear();
    cyc       = 0;
    m_div     = 0;
    m_phase   = 0;
    m_ticks   = 0;
    first_vld = -1;
    m_last    = '0;
    exp_q.delete();
    exp_cyc_q.delete();
    got_q.delete();
  endtask

  // driver: hold reset for n cycles, then release (cycle 0 begins)
  task automatic do_reset(input int n);
    reset = 1'b1;
    @(negedge clk_144);
    chk("reset_toneOut", toneOut, 0, 0);
    chk("reset_valid", sample_valid, 0, 0);
    repeat (n - 1) @(negedge clk_144);
    reset = 1'b0;
    model_clear();
    chk("release_toneOut", toneOut, 0, 0);
    chk("release_valid", sample_valid, 0, 0);
  endtask

  // driver + model: consume the current inputs for one cycle, then check
  task automatic step();
    int v;
    logic exp_v;
    if (m_div == CLK_DIV - 1) begin
      v = enable ? ref_sample(m_phase) : 0;
`ifdef TONE_GEN_GAIN_EN
      v = v >>> gain;
`endif
      exp_q.push_back(16'(v));
      exp_cyc_q.push_back(cyc + 2);
      m_ticks++;
      if (sync)        m_phase = 0;
      else if (enable) m_phase = (m_phase + 32'(freq_word)) % 65536;
      m_div = 0;
    end else begin
      m_div++;
    end
    @(negedge clk_144);
    cyc++;
    exp_v = (exp_cyc_q.size() != 0) && (exp_cyc_q[0] == cyc);
    chk("sample_valid", int'(sample_valid), int'(exp_v), 0);
    if (exp_v) begin
      void'(exp_cyc_q.pop_front());
      m_last = exp_q.pop_front();
    end
    if (sample_valid) begin
      got_q.push_back(toneOut);
      if (first_vld < 0) first_vld = cyc;
    end
    chk("toneOut", toneOut, m_last, 1);
  endtask

  task automatic run_ticks(input int n);
    int target;
    target = m_ticks + n;
    while (m_ticks < target) step();
  endtask

  int pat4[4]    = '{0, 32767, 0, -32767};
  int pat8[8]    = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};
  int pat_en[10] = '{0, 23170, 32767, 0, 0, 0, 0, 23170, 0, -23170};
  int pat_sy[5]  = '{0, 32767, 0, 0, 32767};
  int pat_g[4]   = '{0, 8191, 0, -8192};

  initial begin
    int mx, mn, imx, imn;
    reset     = 1'b1;
    enable    = 1'b1;
    sync      = 1'b0;
    freq_word = 16'd16384;
    gain      = 3'd0;
    model_clear();

    // quarter-rate tone
    do_reset(4);
    repeat (27) step();
    chk("first_valid_cycle", first_vld, 4, 0);
    chk("q4_count_ok", int'(got_q.size() >= 8), 1, 0);
    if (got_q.size() >= 8)
      for (int j = 0; j < 8; j++) chk("q4_seq", got_q[j], pat4[j % 4], 0);

    // eighth-rate tone
    freq_word = 16'd8192;
    do_reset(2);
    repeat (51) step();
    chk("q8_count_ok", int'(got_q.size() >= 16), 1, 0);
    if (got_q.size() >= 16)
      for (int j = 0; j < 16; j++) chk("q8_seq", got_q[j], pat8[j % 8], 0);

    // slow tone, 48 samples per cycle
    freq_word = 16'd1365;
    do_reset(3);
    repeat (146) step();
    chk("slow_count_ok", int'(got_q.size() >= 48), 1, 0);
    if (got_q.size() >= 48) begin
      mx = -40000; mn = 40000; imx = -1; imn = -1;
      for (int j = 0; j < 48; j++) begin
        if (got_q[j] > mx) begin mx = got_q[j]; imx = j; end
        if (got_q[j] < mn) begin mn = got_q[j]; imn = j; end
      end
      chk("slow_peak_idx", imx, 12, 0);
      chk("slow_trough_idx", imn, 36, 0);
      chk("slow_peak", mx, 32767, 16);
      chk("slow_trough", mn, -32767, 16);
    end
    repeat (5) step();

    // mid-tone reset, then enable dropped for four ticks
    freq_word = 16'd8192;
    do_reset(4);
    run_ticks(3);
    enable = 1'b0;
    run_ticks(4);
    enable = 1'b1;
    run_ticks(3);
    repeat (2) step();
    chk("mute_first_valid", first_vld, 4, 0);
    chk("mute_count_ok", int'(got_q.size() >= 10), 1, 0);
    if (got_q.size() >= 10)
      for (int j = 0; j < 10; j++) chk("mute_seq", got_q[j], pat_en[j], 0);

    // sync pulse at a tick
    freq_word = 16'd16384;
    do_reset(2);
    run_ticks(2);
    sync = 1'b1;
    run_ticks(1);
    sync = 1'b0;
    run_ticks(2);
    repeat (2) step();
    chk("sync_count_ok", int'(got_q.size() >= 5), 1, 0);
    if (got_q.size() >= 5)
      for (int j = 0; j < 5; j++) chk("sync_seq", got_q[j], pat_sy[j], 0);

`ifdef TONE_GEN_GAIN_EN
    // attenuated quarter-rate tone
    gain = 3'd2;
    do_reset(2);
    repeat (15) step();
    chk("gain_count_ok", int'(got_q.size() >= 4), 1, 0);
    if (got_q.size() >= 4)
      for (int j = 0; j < 4; j++) chk("gain_seq", got_q[j], pat_g[j], 0);
`endif

    // randomized segments against the model
    for (int s = 0; s < 4; s++) begin
      gain      = 3'($urandom_range(0, 7));
      freq_word = 16'($urandom);
      enable    = 1'b1;
      sync      = 1'b0;
      do_reset($urandom_range(1, 4));
      repeat (300) begin
        if ($urandom_range(0, 29) == 0) freq_word = 16'($urandom);
        enable = ($urandom_range(0, 7) != 0);
        sync   = ($urandom_range(0, 24) == 0);
        step();
      end
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
